// File: rtl/bsg_cache_sbuf_deep_if.sv
// bsg_cache_sbuf_deep_if
//   Handshake/bus bundle for the deep cache store buffer.
//   Producer side : sbuf_entry_i, v_i -> ready_o
//   Consumer side : sbuf_entry_o, v_o <- yumi_i, plus empty_o
//   Snoop side    : bypass_addr_i, bypass_v_i -> bypass_data_o, bypass_mask_o
//   master = the environment (pipeline / data array), slave = the buffer.
//   Entry layout is {addr, data, mask}, most significant first.
interface bsg_cache_sbuf_deep_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
);
    localparam int mask_width_lp  = data_width_p / 8;
    localparam int entry_width_lp = addr_width_p + data_width_p + mask_width_lp;

    logic [entry_width_lp-1:0] sbuf_entry_i;
    logic                      v_i;
    logic                      ready_o;
    logic [entry_width_lp-1:0] sbuf_entry_o;
    logic                      v_o;
    logic                      yumi_i;
    logic                      empty_o;
    logic [addr_width_p-1:0]   bypass_addr_i;
    logic                      bypass_v_i;
    logic [data_width_p-1:0]   bypass_data_o;
    logic [mask_width_lp-1:0]  bypass_mask_o;

    modport master (
        output sbuf_entry_i, v_i, yumi_i, bypass_addr_i, bypass_v_i,
        input  ready_o, sbuf_entry_o, v_o, empty_o, bypass_data_o, bypass_mask_o
    );

    modport slave (
        input  sbuf_entry_i, v_i, yumi_i, bypass_addr_i, bypass_v_i,
        output ready_o, sbuf_entry_o, v_o, empty_o, bypass_data_o, bypass_mask_o
    );
endinterface

// File: rtl/bsg_cache_sbuf_deep.sv
// bsg_cache_sbuf_deep
//   Parametrised store buffer: queues cache write-backs in an els_p-deep
//   circular array, flows a store straight through when empty and consumed
//   in the same cycle, and merges pending bytes for load snoops (result
//   registered, one cycle later).
//   Ports:
//     clk_i   : clock, all state changes on the rising edge
//     reset_i : synchronous active-high reset
//     bus     : bsg_cache_sbuf_deep_if.slave (producer, consumer, snoop)
//   Optional feature macro: BSG_CACHE_SBUF_COALESCE_EN -- when defined, a
//   store to the same word as the youngest stored entry (with at least two
//   entries held) merges into that entry instead of taking a new slot.
module bsg_cache_sbuf_deep #(
    parameter int els_p        = 4,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
) (
    input logic                   clk_i,
    input logic                   reset_i,
    bsg_cache_sbuf_deep_if.slave  bus
);
    localparam int mask_width_lp  = data_width_p / 8;
    localparam int entry_width_lp = addr_width_p + data_width_p + mask_width_lp;
    localparam int lg_els_lp      = $clog2(els_p + 1);
    localparam int ptr_width_lp   = $clog2(els_p);
    localparam int word_lsb_lp    = $clog2(mask_width_lp);
    localparam int word_width_lp  = addr_width_p - word_lsb_lp;

    typedef logic [ptr_width_lp-1:0]   ptr_t;
    typedef logic [entry_width_lp-1:0] entry_t;

    entry_t                  mem_r [els_p];
    ptr_t                    rd_r, wr_r;
    logic [lg_els_lp-1:0]    num_els_r;
    logic [data_width_p-1:0] bypass_data_r;
    logic [mask_width_lp-1:0] bypass_mask_r;

    logic                    empty, ready, hit, enq, deq, flow;
    logic [data_width_p-1:0] byp_data;
    logic [mask_width_lp-1:0] byp_mask;
    logic [word_width_lp-1:0] byp_word;
    entry_t                  src;
    int unsigned             slot;

    function automatic logic [word_width_lp-1:0] word_of(input entry_t e);
        return e[entry_width_lp-1 -: word_width_lp];
    endfunction

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == ptr_t'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (num_els_r == '0);

`ifdef BSG_CACHE_SBUF_COALESCE_EN
    ptr_t                    young;
    entry_t                  young_e;
    entry_t                  coalesced_e;
    logic [data_width_p-1:0] merged_data;

    assign young   = (wr_r == '0) ? ptr_t'(els_p - 1) : wr_r - 1'b1;
    assign young_e = mem_r[young];
    // With two or more entries the youngest can never be the head, so it is
    // safe to modify even when the head is being consumed this cycle.
    assign hit = bus.v_i && (num_els_r >= lg_els_lp'(2))
              && (word_of(young_e) == word_of(bus.sbuf_entry_i));

    always_comb begin
        merged_data = young_e[mask_width_lp +: data_width_p];
        for (int unsigned b = 0; b < mask_width_lp; b++) begin
            if (bus.sbuf_entry_i[b])
                merged_data[b*8 +: 8] = bus.sbuf_entry_i[mask_width_lp + b*8 +: 8];
        end
        coalesced_e = {young_e[entry_width_lp-1 -: addr_width_p], merged_data,
                       young_e[mask_width_lp-1:0] | bus.sbuf_entry_i[mask_width_lp-1:0]};
    end
`else
    assign hit = 1'b0;
`endif

    assign ready = (num_els_r < lg_els_lp'(els_p)) | hit;
    assign flow  = empty & bus.v_i & bus.yumi_i;
    assign enq   = bus.v_i & ready & ~flow & ~hit;
    assign deq   = bus.yumi_i & ~empty;

    assign bus.ready_o       = ready;
    assign bus.empty_o       = empty;
    assign bus.v_o           = empty ? bus.v_i : 1'b1;
    assign bus.sbuf_entry_o  = empty ? bus.sbuf_entry_i : mem_r[rd_r];
    assign bus.bypass_data_o = bypass_data_r;
    assign bus.bypass_mask_o = bypass_mask_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_r      <= '0;
            wr_r      <= '0;
            num_els_r <= '0;
        end else begin
            if (enq) wr_r <= ptr_next(wr_r);
            if (deq) rd_r <= ptr_next(rd_r);
            unique case ({enq, deq})
                2'b10:   num_els_r <= num_els_r + 1'b1;
                2'b01:   num_els_r <= num_els_r - 1'b1;
                default: num_els_r <= num_els_r;
            endcase
        end
    end

    // Entry storage is deliberately not reset; the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wr_r] <= bus.sbuf_entry_i;
`ifdef BSG_CACHE_SBUF_COALESCE_EN
        else if (hit) mem_r[young] <= coalesced_e;
`endif
    end

    // Walk oldest -> youngest -> incoming so later hits overwrite earlier
    // bytes; the head is included even if it is dequeued this cycle.
    assign byp_word = bus.bypass_addr_i[addr_width_p-1:word_lsb_lp];

    always_comb begin
        byp_data = '0;
        byp_mask = '0;
        slot     = '0;
        src      = '0;
        for (int unsigned i = 0; i < els_p; i++) begin
            slot = 32'(rd_r) + i;
            if (slot >= els_p) slot = slot - els_p;
            src = mem_r[slot[ptr_width_lp-1:0]];
            if ((i < 32'(num_els_r)) && (word_of(src) == byp_word)) begin
                for (int unsigned b = 0; b < mask_width_lp; b++) begin
                    if (src[b]) byp_data[b*8 +: 8] = src[mask_width_lp + b*8 +: 8];
                end
                byp_mask = byp_mask | src[mask_width_lp-1:0];
            end
        end
        if (bus.v_i && (word_of(bus.sbuf_entry_i) == byp_word)) begin
            for (int unsigned b = 0; b < mask_width_lp; b++) begin
                if (bus.sbuf_entry_i[b])
                    byp_data[b*8 +: 8] = bus.sbuf_entry_i[mask_width_lp + b*8 +: 8];
            end
            byp_mask = byp_mask | bus.sbuf_entry_i[mask_width_lp-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bypass_data_r <= '0;
            bypass_mask_r <= '0;
        end else if (bus.bypass_v_i) begin
            bypass_data_r <= byp_data;
            bypass_mask_r <= byp_mask;
        end
    end
endmodule

// File: tb/tb_bsg_cache_sbuf_deep.sv
// tb_bsg_cache_sbuf_deep
//   Self-checking bench for bsg_cache_sbuf_deep. A queue-based model of the
//   buffer is compared against the DUT on every falling edge; directed
//   scenarios add literal expectations. A second, 3-deep instance covers
//   pointer wrap-around. Honours BSG_CACHE_SBUF_COALESCE_EN.
module tb_bsg_cache_sbuf_deep;
    localparam int EW = 68;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bsg_cache_sbuf_deep_if #(.addr_width_p(32), .data_width_p(32)) bus  ();
    bsg_cache_sbuf_deep_if #(.addr_width_p(32), .data_width_p(32)) bus3 ();

    bsg_cache_sbuf_deep #(.els_p(4), .addr_width_p(32), .data_width_p(32)) dut (
        .clk_i(clk), .reset_i(rst), .bus(bus.slave));
    bsg_cache_sbuf_deep #(.els_p(3), .addr_width_p(32), .data_width_p(32)) dut3 (
        .clk_i(clk), .reset_i(rst), .bus(bus3.slave));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        return {a, d, m};
    endfunction

    // ---------------- behavioural model ----------------
    logic [EW-1:0] mq[$];
    logic [31:0]   m_bdata;
    logic [3:0]    m_bmask;
    bit            started = 0;
    logic          m_hit_now, m_rdy, m_flow;
    logic [EW-1:0] m_e;
    logic [35:0]   m_bp;

    function automatic logic [29:0] wd(input logic [EW-1:0] e);
        return e[67:38];
    endfunction

    function automatic logic m_hit();
`ifdef BSG_CACHE_SBUF_COALESCE_EN
        if (bus.v_i && mq.size() >= 2 && wd(mq[mq.size()-1]) == wd(bus.sbuf_entry_i)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Per byte: the youngest source holding that byte of the snooped word.
    function automatic logic [35:0] m_bypass();
        logic [31:0]   d = '0;
        logic [3:0]    m = '0;
        logic [29:0]   w = bus.bypass_addr_i[31:2];
        logic [EW-1:0] in = bus.sbuf_entry_i;
        for (int b = 0; b < 4; b++) begin
            if (bus.v_i && wd(in) == w && in[b]) begin
                d[b*8 +: 8] = in[4 + b*8 +: 8];
                m[b] = 1'b1;
            end else begin
                for (int j = mq.size() - 1; j >= 0; j--) begin
                    if (wd(mq[j]) == w && mq[j][b]) begin
                        d[b*8 +: 8] = mq[j][4 + b*8 +: 8];
                        m[b] = 1'b1;
                        break;
                    end
                end
            end
        end
        return {d, m};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_bdata = '0;
            m_bmask = '0;
            started = 1;
        end else begin
            if (bus.bypass_v_i) begin
                m_bp = m_bypass();
                m_bdata = m_bp[35:4];
                m_bmask = m_bp[3:0];
            end
            m_hit_now = m_hit();
            m_rdy     = (mq.size() < 4) || m_hit_now;
            m_flow    = (mq.size() == 0) && bus.v_i && bus.yumi_i;
            if (bus.yumi_i && mq.size() > 0) void'(mq.pop_front());
            if (bus.v_i && m_rdy && !m_flow) begin
                if (m_hit_now) begin
                    m_e = mq[mq.size()-1];
                    for (int b = 0; b < 4; b++)
                        if (bus.sbuf_entry_i[b]) m_e[4 + b*8 +: 8] = bus.sbuf_entry_i[4 + b*8 +: 8];
                    m_e[3:0] = m_e[3:0] | bus.sbuf_entry_i[3:0];
                    mq[mq.size()-1] = m_e;
                end else begin
                    mq.push_back(bus.sbuf_entry_i);
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (started && !rst) begin
            check("ready_o", bus.ready_o, (mq.size() < 4) || m_hit());
            check("v_o", bus.v_o, (mq.size() == 0) ? bus.v_i : 1'b1);
            check("empty_o", bus.empty_o, mq.size() == 0);
            if (mq.size() > 0)
                check("sbuf_entry_o", bus.sbuf_entry_o, mq[0]);
            else if (bus.v_i)
                check("sbuf_entry_o_flow", bus.sbuf_entry_o, bus.sbuf_entry_i);
            check("bypass_data_o", bus.bypass_data_o, m_bdata);
            check("bypass_mask_o", bus.bypass_mask_o, m_bmask);
            assert (!(bus.yumi_i && !bus.v_o)) else $error("yumi_i asserted without v_o");
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic v, input logic [EW-1:0] e, input logic y,
                          input logic bv, input logic [31:0] ba);
        bus.v_i = v; bus.sbuf_entry_i = e; bus.yumi_i = y;
        bus.bypass_v_i = bv; bus.bypass_addr_i = ba;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && mq.size() > 0; k++) begin
            set_in(0, '0, 1, 0, 0);
            tick();
        end
        set_in(0, '0, 0, 0, 0);
        @(negedge clk);
        check("drain_empty", bus.empty_o, 1'b1);
        tick();
    endtask

    logic [EW-1:0] ea, eb, ec, ef, eg, eh;
    logic          rv, ry;
    logic [31:0]   ra;

    initial begin
        rst = 1'b1;
        set_in(0, '0, 0, 0, 0);
        bus3.v_i = 0; bus3.sbuf_entry_i = '0; bus3.yumi_i = 0;
        bus3.bypass_v_i = 0; bus3.bypass_addr_i = '0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_empty", bus.empty_o, 1'b1);
        check("rst_ready", bus.ready_o, 1'b1);
        check("rst_v_o", bus.v_o, 1'b0);
        check("rst_bdata", bus.bypass_data_o, 32'h0);
        check("rst_bmask", bus.bypass_mask_o, 4'h0);
        tick();

        // fill to 4 entries
        for (int k = 0; k < 4; k++) begin
            set_in(1, mk(32'h10 * (k + 1), 32'h1000 + k, 4'hF), 0, k == 2, 32'h30);
            @(negedge clk);
            check("fill_ready", bus.ready_o, 1'b1);
            tick();
        end
        set_in(0, '0, 0, 0, 0);
        @(negedge clk);
        check("full_ready", bus.ready_o, 1'b0);
        check("full_head_addr", bus.sbuf_entry_o[67:36], 32'h10);
        check("full_empty", bus.empty_o, 1'b0);
        check("fill_snoop", {bus.bypass_data_o, bus.bypass_mask_o}, {32'h1002, 4'hF});
        tick();

        // full with simultaneous enqueue/dequeue: store rejected
        set_in(1, mk(32'h50, 32'h5, 4'hF), 1, 0, 0);
        @(negedge clk);
        check("full_enqdeq_ready", bus.ready_o, 1'b0);
        tick();
        set_in(0, '0, 0, 0, 0);
        @(negedge clk);
        check("after_deq_ready", bus.ready_o, 1'b1);
        check("after_deq_head", bus.sbuf_entry_o[67:36], 32'h20);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(0, '0, 1, 0, 0);
            @(negedge clk);
            check("drain_order", bus.sbuf_entry_o[67:36], 32'h20 + 32'h10 * k);
            tick();
        end
        set_in(0, '0, 0, 0, 0);
        @(negedge clk);
        check("no_extra_entry", bus.empty_o, 1'b1);
        tick();

        // flow-through
        ea = mk(32'h80, 32'hCAFEF00D, 4'hF);
        set_in(1, ea, 1, 0, 0);
        @(negedge clk);
        check("flow_entry", bus.sbuf_entry_o, ea);
        check("flow_v_o", bus.v_o, 1'b1);
        tick();
        set_in(0, '0, 0, 0, 0);
        @(negedge clk);
        check("flow_empty_after", bus.empty_o, 1'b1);
        tick();

        // bypass merge
        ea = mk(32'h100, 32'h11223344, 4'h3);
        eb = mk(32'h100, 32'hAABBCCDD, 4'h6);
        ec = mk(32'h100, 32'h55667788, 4'h8);
        set_in(1, ea, 0, 0, 0); tick();
        set_in(1, eb, 0, 0, 0); tick();
        set_in(1, ec, 0, 1, 32'h102); tick();
        set_in(0, '0, 0, 1, 32'h200); // miss snoop
        @(negedge clk);
        check("byp_data", bus.bypass_data_o, 32'h55BBCC44);
        check("byp_mask", bus.bypass_mask_o, 4'hF);
        tick();
        set_in(0, '0, 1, 1, 32'h101); // head dequeued during snoop
        @(negedge clk);
        check("byp_miss_mask", bus.bypass_mask_o, 4'h0);
        check("byp_miss_data", bus.bypass_data_o, 32'h0);
        tick();
        set_in(0, '0, 0, 0, 0);
        @(negedge clk);
        check("byp_deq_data", bus.bypass_data_o, 32'h55BBCC44);
        check("byp_deq_mask", bus.bypass_mask_o, 4'hF);
        tick();
        drain();

        // coalescing into the youngest entry
        ef = mk(32'h1F0, 32'h12345678, 4'hF);
        eg = mk(32'h200, 32'h000000AB, 4'h1);
        eh = mk(32'h203, 32'hEE000000, 4'h8);
        set_in(1, ef, 0, 0, 0); tick();
        set_in(1, eg, 0, 0, 0); tick();
        set_in(1, eh, 0, 0, 0); tick();
        set_in(0, '0, 0, 1, 32'h200); tick();
        set_in(0, '0, 1, 0, 0);
        @(negedge clk);
        check("coal_bdata", bus.bypass_data_o, 32'hEE0000AB);
        check("coal_bmask", bus.bypass_mask_o, 4'h9);
        tick();
        tick();
        set_in(0, '0, 0, 0, 0);
        @(negedge clk);
`ifdef BSG_CACHE_SBUF_COALESCE_EN
        check("coal_count2_empty", bus.empty_o, 1'b1);
`else
        check("nocoal_count3_empty", bus.empty_o, 1'b0);
`endif
        tick();
        drain();

        // store to the youngest word while full
        for (int k = 0; k < 4; k++) begin
            set_in(1, mk(32'h400 + 32'h10 * k, 32'h7, 4'h1), 0, 0, 0);
            tick();
        end
        set_in(1, mk(32'h431, 32'h00990000, 4'h4), 0, 0, 0);
        @(negedge clk);
`ifdef BSG_CACHE_SBUF_COALESCE_EN
        check("coal_full_ready", bus.ready_o, 1'b1);
`else
        check("nocoal_full_ready", bus.ready_o, 1'b0);
`endif
        tick();
        drain();

        // model-checked pseudo-random traffic with one mid-run reset
        for (int it = 0; it < 300; it++) begin
            rv = 1'($urandom_range(0, 1));
            ra = 32'h300 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
            if (mq.size() > 0) ry = 1'($urandom_range(0, 1));
            else ry = rv & 1'($urandom_range(0, 1));
            set_in(rv, mk(ra, $urandom, 4'($urandom_range(0, 15))), ry,
                   1'($urandom_range(0, 1)),
                   32'h300 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)));
            rst = (it == 150);
            if (rst) bus.yumi_i = 1'b0;
            tick();
        end
        rst = 1'b0;
        drain();

        // wrap-around on the 3-deep instance at occupancy 2
        bus3.v_i = 1; bus3.yumi_i = 0; bus3.sbuf_entry_i = mk(32'h1000, 32'd0, 4'hF); tick();
        bus3.sbuf_entry_i = mk(32'h1010, 32'd1, 4'hF); tick();
        for (int k = 2; k < 12; k++) begin
            bus3.v_i = 1; bus3.yumi_i = 1;
            bus3.sbuf_entry_i = mk(32'h1000 + 32'h10 * k, 32'(k), 4'hF);
            @(negedge clk);
            check("wrap_order", bus3.sbuf_entry_o[35:4], 32'(k - 2));
            check("wrap_ready", bus3.ready_o, 1'b1);
            tick();
        end
        bus3.v_i = 0;
        for (int k = 10; k < 12; k++) begin
            bus3.yumi_i = 1;
            @(negedge clk);
            check("wrap_tail", bus3.sbuf_entry_o[35:4], 32'(k));
            tick();
        end
        bus3.yumi_i = 0;
        @(negedge clk);
        check("wrap_empty", bus3.empty_o, 1'b1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end
endmodule
